// File: rtl/usb3_pkg.sv
// usb3_pkg: FT601 bus widths, FSM encoding and active-low levels shared by the USB3 tx/rx interfaces
package usb3_pkg;
  localparam int FT_DATA_W = 32;
  localparam int FT_BE_W = 4;
  localparam logic ACT_LO = 1'b0;
  localparam logic INACT = 1'b1;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_TURN = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;
  typedef struct packed {
    logic [FT_BE_W-1:0] be;
    logic [FT_DATA_W-1:0] data;
  } ft_word_t;
endpackage

// File: rtl/usb3_tx_if_if.sv
// usb3_tx_if_if: FPGA-side push handshake plus FT601 transmit pins
//  slave  : the transmit interface block (consumes tx_*, FT_TXE; drives FT_WR/FT_OE and pads)
//  master : FPGA logic and FT601 pins around it
interface usb3_tx_if_if;
  import usb3_pkg::*;
  logic [FT_DATA_W-1:0] tx_data;
  logic [FT_BE_W-1:0] tx_be;
  logic tx_valid;
  logic tx_ready;
  logic FT_TXE;
  logic FT_WR;
  logic FT_OE;
  logic [FT_DATA_W-1:0] usb3_data_out;
  logic [FT_BE_W-1:0] usb3_be_out;
  logic usb3_bus_oe;
  modport slave (
    input tx_data, tx_be, tx_valid, FT_TXE,
    output tx_ready, FT_WR, FT_OE, usb3_data_out, usb3_be_out, usb3_bus_oe
  );
  modport master (
    output tx_data, tx_be, tx_valid, FT_TXE,
    input tx_ready, FT_WR, FT_OE, usb3_data_out, usb3_be_out, usb3_bus_oe
  );
endinterface

// File: rtl/usb3_tx_fifo.sv
// usb3_tx_fifo: synchronous first-word-fall-through FIFO of {be,data} words
//  clk/rst   clock, sync active-high reset
//  push/pop  write wr_word / drop head (caller guarantees not full / not empty)
//  head      current head word; head_next is the word that becomes head after a pop
//  level     words held, 0..DEPTH
module usb3_tx_fifo
  import usb3_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  ft_word_t wr_word,
  output ft_word_t head,
  output ft_word_t head_next,
  output logic [AW:0] level
);
  ft_word_t mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, rd_nxt;
  assign rd_nxt = rd_ptr + 1'b1;
  assign head = mem[rd_ptr];
  // With only one word held, the word after it is the one being pushed this cycle.
  assign head_next = |level[AW:1] ? mem[rd_nxt] : wr_word;
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_word;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/usb3_tx_if.sv
// usb3_tx_if: FT601 245-sync FIFO transmit side, buffers words and bursts them under TXE_N flow control
//  ftdi_clk/reset  only clock, sync active-high reset
//  enable          allows bursts to start/continue
//  bus             tx_* push handshake in, FT_TXE in; FT_WR, FT_OE, data/BE pads and pad OE out
//  fifo_level      words buffered; words_sent counts words taken by the FT601; busy = not IDLE
module usb3_tx_if
  import usb3_pkg::*;
#(
  parameter int FIFO_DEPTH = 64,
  parameter int ADDR_W = 6
) (
  input  logic ftdi_clk,
  input  logic reset,
  input  logic enable,
  usb3_tx_if_if.slave bus,
  output logic [ADDR_W:0] fifo_level,
  output logic [31:0] words_sent,
  output logic busy
);
  logic [1:0] state;
  ft_word_t head, head_next;
  logic push, xfer, more;
  assign bus.tx_ready = fifo_level != (ADDR_W+1)'(FIFO_DEPTH);
  assign push = bus.tx_valid & bus.tx_ready;
  assign xfer = bus.FT_WR == ACT_LO && bus.FT_TXE == ACT_LO;
  // Keep bursting only if a word remains once the head leaves (a same-cycle push counts).
  assign more = enable & (|fifo_level[ADDR_W:1] | push);
  assign busy = state != ST_IDLE;
  usb3_tx_fifo #(.DEPTH(FIFO_DEPTH), .AW(ADDR_W)) u_fifo (
    .clk(ftdi_clk),
    .rst(reset),
    .push(push),
    .pop(xfer),
    .wr_word({bus.tx_be, bus.tx_data}),
    .head(head),
    .head_next(head_next),
    .level(fifo_level)
  );
  always_ff @(posedge ftdi_clk) begin
    if (reset) begin
      state <= ST_IDLE;
      bus.FT_WR <= INACT;
      bus.FT_OE <= INACT;
      bus.usb3_bus_oe <= 1'b0;
      bus.usb3_data_out <= '0;
      bus.usb3_be_out <= '0;
      words_sent <= '0;
    end else begin
      words_sent <= words_sent + 32'(xfer);
      case (state)
        ST_IDLE:
          if (enable && |fifo_level && bus.FT_TXE == ACT_LO) begin
            state <= ST_TURN;
            bus.usb3_bus_oe <= 1'b1;
            {bus.usb3_be_out, bus.usb3_data_out} <= head;
          end
        ST_TURN: begin
          state <= ST_WRITE;
          bus.FT_WR <= ACT_LO;
        end
        ST_WRITE:
          if (bus.FT_TXE == ACT_LO) begin
            if (more) {bus.usb3_be_out, bus.usb3_data_out} <= head_next;
            else begin
              state <= ST_IDLE;
              bus.FT_WR <= INACT;
              bus.usb3_bus_oe <= 1'b0;
            end
          end else begin
            state <= ST_HOLD;
            bus.FT_WR <= INACT;
          end
        ST_HOLD:
          if (!enable) begin
            state <= ST_IDLE;
            bus.usb3_bus_oe <= 1'b0;
          end else if (bus.FT_TXE == ACT_LO) begin
            state <= ST_WRITE;
            bus.FT_WR <= ACT_LO;
          end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_usb3_tx_if.sv
// tb_usb3_tx_if: table-driven and directed checks of usb3_tx_if with a word-order scoreboard
module tb_usb3_tx_if;
  import usb3_pkg::*;
  localparam logic H = 1'b1, L = 1'b0;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b1;
  logic [6:0] fifo_level;
  logic [31:0] words_sent;
  logic busy;
  int total = 0, bad = 0, sent = 0;
  ft_word_t exp_q[$];
  usb3_tx_if_if bus();
  usb3_tx_if dut (
    .ftdi_clk(clk),
    .reset(reset),
    .enable(enable),
    .bus(bus),
    .fifo_level(fifo_level),
    .words_sent(words_sent),
    .busy(busy)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic v;
    logic [31:0] d;
    logic [3:0] be;
    logic txe, en, wr, oe;
    logic [31:0] xd;
    logic [3:0] xbe;
    logic [6:0] lvl;
    logic [31:0] ws;
    logic bsy;
  } vec_t;
  vec_t tbl[23];
  function automatic vec_t mk(logic v, logic [31:0] d, logic [3:0] be, logic txe, logic en,
                              logic wr, logic oe, logic [31:0] xd, logic [3:0] xbe,
                              logic [6:0] lvl, logic [31:0] ws, logic bsy);
    mk = '{v, d, be, txe, en, wr, oe, xd, xbe, lvl, ws, bsy};
  endfunction
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic expire(string nm);
    total++;
    bad++;
    $display("FAIL %s: bound expired without the expected event", nm);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // Words transfer on the coming edge when WR_N and TXE_N are both low at the negedge.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      sent = 0;
    end else begin
      if (bus.FT_WR == ACT_LO && bus.FT_TXE == ACT_LO) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_extra: got %h want no transfer", bus.usb3_data_out);
        end else chk("sb_word", 64'({bus.usb3_be_out, bus.usb3_data_out}), 64'(exp_q.pop_front()));
        sent++;
      end
      if (bus.tx_valid && bus.tx_ready) exp_q.push_back(ft_word_t'({bus.tx_be, bus.tx_data}));
    end
  end
  task automatic preload(int n, logic [31:0] base, logic [15:0] bes);
    int k = 0;
    for (int c = 0; c < 200 && k < n; c++) begin
      bus.tx_valid = 1'b1;
      bus.tx_data = base + 32'(k);
      bus.tx_be = k < 4 ? bes[k*4 +: 4] : 4'hF;
      if (bus.tx_ready) k++;
      tick();
    end
    bus.tx_valid = 1'b0;
    if (k < n) expire("preload");
  endtask
  task automatic find_wr(string nm, logic use_d, logic [31:0] d);
    logic ok = 1'b0;
    for (int c = 0; c < 60 && !ok; c++) begin
      tick();
      ok = bus.FT_WR == ACT_LO && (!use_d || bus.usb3_data_out == d);
    end
    if (!ok) expire(nm);
  endtask
  task automatic wait_idle(string nm);
    int c = 0;
    while (c < 300 && (busy || fifo_level != 0)) begin
      tick();
      c++;
    end
    if (c == 300) expire(nm);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int ws0, lows, first, last, k, idx, pp;
    logic acc, pop_now;
    logic [6:0] lvl_b;
    logic [15:0] bpat;
    bpat = 16'hF731;
    bus.tx_valid = 1'b0;
    bus.tx_data = '0;
    bus.tx_be = '0;
    bus.FT_TXE = H;
    tick();
    tick();
    chk("rst_wr", 64'(bus.FT_WR), 64'(1));
    chk("rst_oe", 64'(bus.usb3_bus_oe), 64'(0));
    chk("rst_lvl", 64'(fifo_level), 64'(0));
    chk("rst_ws", 64'(words_sent), 64'(0));
    reset = 1'b0;
    tick();
    chk("rst_ready", 64'(bus.tx_ready), 64'(1));
    chk("rst_ftoe", 64'(bus.FT_OE), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_data", 64'(bus.usb3_data_out), 64'(0));
    tbl[0] = mk(H, 32'hA1, 4'hF, L, H, H, L, 32'h0, 4'h0, 7'd1, 32'd0, L);
    tbl[1] = mk(H, 32'hA2, 4'h3, L, H, H, H, 32'hA1, 4'hF, 7'd2, 32'd0, H);
    tbl[2] = mk(H, 32'hA3, 4'h1, L, H, L, H, 32'hA1, 4'hF, 7'd3, 32'd0, H);
    tbl[3] = mk(L, 32'h0, 4'h0, L, H, L, H, 32'hA2, 4'h3, 7'd2, 32'd1, H);
    tbl[4] = mk(L, 32'h0, 4'h0, H, H, H, H, 32'hA2, 4'h3, 7'd2, 32'd1, H);
    tbl[5] = mk(L, 32'h0, 4'h0, H, H, H, H, 32'hA2, 4'h3, 7'd2, 32'd1, H);
    tbl[6] = mk(L, 32'h0, 4'h0, L, H, L, H, 32'hA2, 4'h3, 7'd2, 32'd1, H);
    tbl[7] = mk(H, 32'hA4, 4'h7, L, H, L, H, 32'hA3, 4'h1, 7'd2, 32'd2, H);
    tbl[8] = mk(L, 32'h0, 4'h0, L, H, L, H, 32'hA4, 4'h7, 7'd1, 32'd3, H);
    tbl[9] = mk(L, 32'h0, 4'h0, L, H, H, L, 32'h0, 4'h0, 7'd0, 32'd4, L);
    tbl[10] = mk(H, 32'hB1, 4'hF, L, H, H, L, 32'h0, 4'h0, 7'd1, 32'd4, L);
    tbl[11] = mk(L, 32'h0, 4'h0, L, H, H, H, 32'hB1, 4'hF, 7'd1, 32'd4, H);
    tbl[12] = mk(L, 32'h0, 4'h0, L, H, L, H, 32'hB1, 4'hF, 7'd1, 32'd4, H);
    tbl[13] = mk(H, 32'hB2, 4'h3, L, H, L, H, 32'hB2, 4'h3, 7'd1, 32'd5, H);
    tbl[14] = mk(L, 32'h0, 4'h0, L, H, H, L, 32'h0, 4'h0, 7'd0, 32'd6, L);
    tbl[15] = mk(H, 32'hC1, 4'hF, H, H, H, L, 32'h0, 4'h0, 7'd1, 32'd6, L);
    tbl[16] = mk(L, 32'h0, 4'h0, L, H, H, H, 32'hC1, 4'hF, 7'd1, 32'd6, H);
    tbl[17] = mk(L, 32'h0, 4'h0, L, H, L, H, 32'hC1, 4'hF, 7'd1, 32'd6, H);
    tbl[18] = mk(L, 32'h0, 4'h0, H, H, H, H, 32'hC1, 4'hF, 7'd1, 32'd6, H);
    tbl[19] = mk(L, 32'h0, 4'h0, L, L, H, L, 32'h0, 4'h0, 7'd1, 32'd6, L);
    tbl[20] = mk(L, 32'h0, 4'h0, L, H, H, H, 32'hC1, 4'hF, 7'd1, 32'd6, H);
    tbl[21] = mk(L, 32'h0, 4'h0, L, H, L, H, 32'hC1, 4'hF, 7'd1, 32'd6, H);
    tbl[22] = mk(L, 32'h0, 4'h0, L, H, H, L, 32'h0, 4'h0, 7'd0, 32'd7, L);
    for (int i = 0; i < 23; i++) begin
      bus.tx_valid = tbl[i].v;
      bus.tx_data = tbl[i].d;
      bus.tx_be = tbl[i].be;
      bus.FT_TXE = tbl[i].txe;
      enable = tbl[i].en;
      tick();
      chk($sformatf("v%0d_wr", i), 64'(bus.FT_WR), 64'(tbl[i].wr));
      chk($sformatf("v%0d_oe", i), 64'(bus.usb3_bus_oe), 64'(tbl[i].oe));
      chk($sformatf("v%0d_lvl", i), 64'(fifo_level), 64'(tbl[i].lvl));
      chk($sformatf("v%0d_ws", i), 64'(words_sent), 64'(tbl[i].ws));
      chk($sformatf("v%0d_busy", i), 64'(busy), 64'(tbl[i].bsy));
      if (tbl[i].oe) begin
        chk($sformatf("v%0d_data", i), 64'(bus.usb3_data_out), 64'(tbl[i].xd));
        chk($sformatf("v%0d_be", i), 64'(bus.usb3_be_out), 64'(tbl[i].xbe));
      end
    end
    bus.tx_valid = L;
    enable = H;
    ws0 = words_sent;
    lows = 0;
    first = -1;
    last = -1;
    k = 0;
    bus.FT_TXE = L;
    for (int c = 0; c < 40; c++) begin
      bus.tx_valid = k < 8;
      bus.tx_data = 32'(k + 1);
      bus.tx_be = 4'hF;
      if (bus.tx_valid && bus.tx_ready) k++;
      tick();
      if (bus.FT_WR == ACT_LO) begin
        lows++;
        if (first < 0) first = c;
        last = c;
      end
    end
    bus.tx_valid = L;
    chk("t2_lows", 64'(lows), 64'(8));
    chk("t2_contig", 64'(last - first), 64'(7));
    chk("t2_ws", 64'(words_sent - ws0), 64'(8));
    chk("t2_busy", 64'(busy), 64'(0));
    chk("t2_oe", 64'(bus.usb3_bus_oe), 64'(0));
    chk("t2_sent", 64'(words_sent), 64'(sent));
    bus.FT_TXE = H;
    ws0 = words_sent;
    preload(8, 32'h1, 16'hFFFF);
    bus.FT_TXE = L;
    find_wr("t3_find", H, 32'h3);
    bus.FT_TXE = H;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t3_hold_wr", 64'(bus.FT_WR), 64'(1));
      chk("t3_hold_data", 64'(bus.usb3_data_out), 64'(3));
      chk("t3_hold_oe", 64'(bus.usb3_bus_oe), 64'(1));
    end
    bus.FT_TXE = L;
    wait_idle("t3_idle");
    chk("t3_ws", 64'(words_sent - ws0), 64'(8));
    chk("t3_sent", 64'(words_sent), 64'(sent));
    bus.FT_TXE = H;
    ws0 = words_sent;
    preload(64, 32'h100, 16'hFFFF);
    chk("t4_full_lvl", 64'(fifo_level), 64'(64));
    chk("t4_full_ready", 64'(bus.tx_ready), 64'(0));
    bus.FT_TXE = L;
    k = 0;
    pp = 0;
    for (int c = 0; c < 200 && k < 20; c++) begin
      bus.tx_valid = H;
      bus.tx_data = 32'h200 + 32'(k);
      bus.tx_be = 4'hF;
      acc = bus.tx_ready;
      pop_now = bus.FT_WR == ACT_LO;
      lvl_b = fifo_level;
      if (acc) k++;
      tick();
      if (acc && pop_now) begin
        chk("t4_keep", 64'(fifo_level), 64'(lvl_b));
        pp++;
      end
    end
    bus.tx_valid = L;
    chk("t4_pushpop_seen", 64'(pp != 0), 64'(1));
    wait_idle("t4_idle");
    chk("t4_ws", 64'(words_sent - ws0), 64'(84));
    chk("t4_sent", 64'(words_sent), 64'(sent));
    bus.FT_TXE = H;
    ws0 = words_sent;
    preload(10, 32'h1, 16'hFFFF);
    bus.FT_TXE = L;
    find_wr("t5_find", H, 32'h4);
    enable = L;
    tick();
    chk("t5_busy", 64'(busy), 64'(0));
    chk("t5_wr", 64'(bus.FT_WR), 64'(1));
    chk("t5_oe", 64'(bus.usb3_bus_oe), 64'(0));
    chk("t5_lvl", 64'(fifo_level), 64'(6));
    chk("t5_ws", 64'(words_sent - ws0), 64'(4));
    tick();
    tick();
    tick();
    chk("t5_lvl_hold", 64'(fifo_level), 64'(6));
    chk("t5_wr_hold", 64'(bus.FT_WR), 64'(1));
    enable = H;
    find_wr("t5_resume", L, 32'h0);
    chk("t5_resume_data", 64'(bus.usb3_data_out), 64'(5));
    wait_idle("t5_idle");
    chk("t5_ws_all", 64'(words_sent - ws0), 64'(10));
    bus.FT_TXE = H;
    preload(4, 32'h60, bpat);
    bus.FT_TXE = L;
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.FT_WR == ACT_LO && idx < 4) begin
        chk($sformatf("t6_be%0d", idx), 64'(bus.usb3_be_out), 64'(bpat[idx*4 +: 4]));
        idx++;
      end
    end
    chk("t6_count", 64'(idx), 64'(4));
    bus.FT_TXE = H;
    preload(8, 32'h50, 16'hFFFF);
    bus.FT_TXE = L;
    find_wr("t1_find", L, 32'h0);
    tick();
    reset = H;
    tick();
    chk("t1_wr", 64'(bus.FT_WR), 64'(1));
    chk("t1_oe", 64'(bus.usb3_bus_oe), 64'(0));
    tick();
    chk("t1_lvl", 64'(fifo_level), 64'(0));
    chk("t1_ws", 64'(words_sent), 64'(0));
    chk("t1_busy", 64'(busy), 64'(0));
    reset = L;
    bus.FT_TXE = H;
    tick();
    chk("t1_ready", 64'(bus.tx_ready), 64'(1));
    chk("t1_wr_after", 64'(bus.FT_WR), 64'(1));
    chk("t1_ftoe", 64'(bus.FT_OE), 64'(1));
    chk("t1_data", 64'({bus.usb3_be_out, bus.usb3_data_out}), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
